// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shift engine: MSB-first, with a single-word transmit holding register.
// SCLK edges arrive as one-cycle pulses already synchronised to clock.
module spi_slave_shifter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  sclk_pos,
  input  logic                  sclk_neg,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {StIdle, StActive} state_e;

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  consume;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    consume    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // After reset a fresh cs_n high is required before a new transaction may start.
        if (!cs_n && armed_q) begin
          state_d = StActive;
          consume = 1'b1;
        end
      end
      StActive: begin
        if (cs_n) begin
          state_d    = StIdle;
          cnt_d      = '0;
          rx_shift_d = '0;
        end else if (sclk_pos) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi};
          if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
            cnt_d      = '0;
            rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi};
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (sclk_neg) begin
          if (cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end else begin
            consume = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (cs_n) begin
      armed_d = 1'b1;
    end

    if (consume) begin
      tx_shift_d = tx_ready_q ? '0 : hold_q;
      underrun_d = tx_ready_q;
      tx_ready_d = 1'b1;
    end

    // A consume frees the holding register in the same cycle, so a coincident load is taken.
    if (tx_load && (tx_ready_q || consume)) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign miso        = (state_q == StActive) && tx_shift_q[DATA_WIDTH-1];
  assign busy        = (state_q == StActive);
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule
